// File: rtl/down_counter_timer_pkg.sv
// rtl/down_counter_timer_pkg.sv - shared state type and defaults for the down-counter timer
package dncnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dncnt_state_t;

  localparam int DNCNT_DEFAULT_WIDTH = 12;

endpackage

// File: rtl/down_counter_timer_if.sv
// rtl/down_counter_timer_if.sv - control/status bundle between a sequencer and the timer
interface down_counter_timer_if #(
  parameter int WIDTH = dncnt_pkg::DNCNT_DEFAULT_WIDTH
);
  logic             enable;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc_pulse;
  logic             done;

  modport master (
    output enable, start, stop, auto_reload, load_value,
    input  count, busy, tc_pulse, done
  );

  modport slave (
    input  enable, start, stop, auto_reload, load_value,
    output count, busy, tc_pulse, done
  );
endinterface

// File: rtl/down_counter_timer_prescaler.sv
// rtl/down_counter_timer_prescaler.sv - divide-by-DIV tick generator, built only with DNCNT_PRESCALE_EN
module dncnt_prescaler #(
  parameter int unsigned DIV = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = run && (cnt_q == PW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable one-shot / periodic down-counter timer
// Optional prescaler tick divider enabled by defining DNCNT_PRESCALE_EN.
module down_counter_timer
  import dncnt_pkg::*;
#(
  parameter int          WIDTH        = DNCNT_DEFAULT_WIDTH,
  parameter int unsigned PRESCALE_DIV = 16
) (
  input logic                  clock,
  input logic                  reset_n,
  down_counter_timer_if.slave  bus
);
  dncnt_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;
  logic             run_en;
  logic             tick;

  assign run_en = (state_q == RUN) && bus.enable;

`ifdef DNCNT_PRESCALE_EN
  logic presc_tick;
  logic presc_clear;

  // A one-shot terminal event always lands on a wrap, so this clear only makes the reset-to-0 explicit.
  assign presc_clear = bus.start || bus.stop || (tick && (count_q == '0) && !mode_q);

  dncnt_prescaler #(.DIV(PRESCALE_DIV)) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (presc_clear),
    .run     (run_en),
    .tick    (presc_tick)
  );

  assign tick = presc_tick;
`else
  logic unused_prescale_div;
  assign unused_prescale_div = ^PRESCALE_DIV;
  assign tick = run_en;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    done_d   = done_q;
    tc_d     = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (bus.start) begin
      state_d  = RUN;
      count_d  = bus.load_value;
      reload_d = bus.load_value;
      mode_d   = bus.auto_reload;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end else if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        if (mode_q) begin
          count_d = reload_q;
        end else begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.busy     = busy_q;
  assign bus.tc_pulse = tc_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - self-checking bench for down_counter_timer (default build)
module tb_down_counter_timer;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        st;
    logic        sp;
    logic        ar;
    logic [11:0] ld;
    logic [11:0] c;
    logic        b;
    logic        tc;
    logic        d;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;

  down_counter_timer_if #(.WIDTH(12)) bus ();

  down_counter_timer #(.WIDTH(12), .PRESCALE_DIV(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   vidx     = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d required=%0d", name, vidx, act, exp);
    end
  endtask

  function automatic void add(input int rst_n, input int en, input int st, input int sp,
                              input int ar, input int ld, input int c, input int b,
                              input int tc, input int d);
    vec_t v;
    v.rst_n = rst_n[0];
    v.en    = en[0];
    v.st    = st[0];
    v.sp    = sp[0];
    v.ar    = ar[0];
    v.ld    = 12'(ld);
    v.c     = 12'(c);
    v.b     = b[0];
    v.tc    = tc[0];
    v.d     = d[0];
    vecs.push_back(v);
  endfunction

  task automatic step(input vec_t v);
    vec_t e;
    reset_n         = v.rst_n;
    bus.enable      = v.en;
    bus.start       = v.st;
    bus.stop        = v.sp;
    bus.auto_reload = v.ar;
    bus.load_value  = v.ld;
    sb.push_back(v);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("count", int'(bus.count), int'(e.c));
    check("busy", int'(bus.busy), int'(e.b));
    check("tc_pulse", int'(bus.tc_pulse), int'(e.tc));
    check("done", int'(bus.done), int'(e.d));
    vidx++;
  endtask

  initial begin
    int n;
    int found;
    reset_n         = 1'b0;
    bus.enable      = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.auto_reload = 1'b0;
    bus.load_value  = '0;

    // reset state
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 9, 0, 0, 0, 0);
    // one-shot from 5
    add(1, 1, 1, 0, 0, 5, 5, 1, 0, 0);
    for (int c = 4; c >= 0; c--) add(1, 1, 0, 0, 0, 0, c, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    // periodic from 3; auto_reload is low after start to show mode is latched
    add(1, 1, 1, 0, 1, 3, 3, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      int m;
      m = i % 4;
      add(1, 1, 0, 0, 0, 0, (m == 3) ? 3 : 2 - m, 1, (m == 3) ? 1 : 0, 0);
    end
    add(1, 1, 0, 1, 0, 0, 3, 0, 0, 0);
    // enable gating at count 6
    add(1, 1, 1, 0, 0, 10, 10, 1, 0, 0);
    for (int c = 9; c >= 6; c--) add(1, 1, 0, 0, 0, 0, c, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 4, 0, 0, 0);
    // stop beats simultaneous start
    add(1, 1, 1, 1, 0, 7, 4, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4, 0, 0, 0);
    // restart while running
    add(1, 1, 1, 0, 0, 50, 50, 1, 0, 0);
    for (int c = 49; c >= 40; c--) add(1, 1, 0, 0, 0, 0, c, 1, 0, 0);
    add(1, 1, 1, 0, 0, 100, 100, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 100, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 100, 0, 0, 0);
    // load 0 one-shot and periodic
    add(1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 1, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    for (int k = 0; k < vecs.size(); k++) step(vecs[k]);

    // full-scale periodic: 4095 down through 0 and reload without glitch
    vecs.delete();
    add(1, 1, 1, 0, 1, 4095, 4095, 1, 0, 0);
    for (int i = 1; i <= 4095; i++) add(1, 1, 0, 0, 0, 0, 4095 - i, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4095, 1, 1, 0);
    add(1, 1, 0, 0, 0, 0, 4094, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4093, 1, 0, 0);
    // reset mid-run, with a start asserted that reset must override
    add(0, 1, 1, 0, 1, 33, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < vecs.size(); k++) step(vecs[k]);

    // first tc_pulse latency: load_value+2 cycles after the start cycle
    reset_n         = 1'b1;
    bus.enable      = 1'b1;
    bus.stop        = 1'b0;
    bus.auto_reload = 1'b0;
    bus.load_value  = 12'd7;
    bus.start       = 1'b1;
    n     = 0;
    found = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      n++;
      if (bus.tc_pulse) begin
        found = 1;
        break;
      end
    end
    check("tc_found", found, 1);
    check("tc_latency", n, 9);
    check("done_at_tc", int'(bus.done), 1);
    check("busy_at_tc", int'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counter timer for the gyro tester common IP. It complements the free-running up counter used for elapsed-time measurement.
- Software or a sequencer loads a start value and starts the timer. The block counts down while enabled and flags terminal count.
- Two modes: one-shot (stops at zero) and auto-reload (periodic tick generator). Used for sample-interval and timeout generation.

Parameters:
- WIDTH, 12: counter and load-value width in bits.
- PRESCALE_DIV, 16: clock cycles per count tick. Only used when DNCNT_PRESCALE_EN is defined; must be ≥2.

Ports:
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: reset, synchronous, active-low.
- enable, input, 1: count-tick qualifier. Low freezes count, state and prescaler.
- start, input, 1: single-cycle request to load and run.
- stop, input, 1: single-cycle abort request.
- auto_reload, input, 1: mode select, sampled only on an accepted start. 1 = periodic, 0 = one-shot.
- load_value, input, WIDTH: start value, sampled only on an accepted start.
- count, output, WIDTH: current counter value, registered.
- busy, output, 1: high while in RUN.
- tc_pulse, output, 1: one-cycle pulse on each terminal-count event.
- done, output, 1: one-shot completion flag; level, held until cleared.

Behaviour:
- Reset (reset_n=0 at a rising edge; synchronous, overrides all):
  - state=IDLE, count=0, busy=0, done=0, tc_pulse=0.
  - Internal reload register=0, mode register=0, prescaler=0.
  - Reset mid-RUN aborts immediately; no tc_pulse is generated.
- States:
  - IDLE: waiting for start.
  - RUN: counting down.
  - DONE: one-shot finished.
- Accepted start (start=1, stop=0, any state):
  - Next cycle: count=load_value, reload register=load_value, mode register=auto_reload.
  - Also next cycle: state=RUN, busy=1, done=0, prescaler=0.
  - Start while in RUN restarts from the new load_value.
- stop=1 (any state):
  - Next cycle: state=IDLE, busy=0, done=0, tc_pulse=0.
  - count holds its current value.
  - stop has priority over a simultaneous start.
- Tick in RUN: enable=1, plus prescaler wrap when the option is enabled.
  - count≠0: count <= count-1.
  - count==0: terminal event; tc_pulse=1 on the next cycle for exactly one cycle.
    - Periodic mode: count <= reload register, state stays RUN.
    - One-shot mode: count stays 0, state=DONE, busy=0, done=1.
- Period and latency:
  - Period is (load_value+1) ticks.
  - load_value=0 gives a terminal event on the first tick.
  - With no prescaler and enable held high, the first tc_pulse appears load_value+2 cycles after the start cycle.
- enable=0 in RUN: count, prescaler and state hold; no tick; stop and start still act.
- DONE: holds count=0 and done=1 until start, stop or reset.
- Arithmetic: unsigned, modulo 2^WIDTH. Underflow below 0 never occurs because 0 is handled as the terminal event.
- tc_pulse is 0 in every cycle other than the one following a terminal event.

Optional Feature:
- Macro DNCNT_PRESCALE_EN defined:
  - A prescaler counter runs only in RUN with enable=1.
  - A tick occurs when the prescaler equals PRESCALE_DIV-1; the prescaler then wraps to 0.
  - The prescaler clears on accepted start, stop, reset and terminal event in one-shot mode.
- Macro not defined: every RUN cycle with enable=1 is a tick; PRESCALE_DIV is ignored and no prescaler logic is built.

Decomposition:
- Package dncnt_pkg holds:
  - the state enum type dncnt_state_t (IDLE, RUN, DONE), 2-bit encoding;
  - the constant DNCNT_DEFAULT_WIDTH=12.
- Sub-module dncnt_prescaler contains the divide-by-PRESCALE_DIV tick generator, instantiated only under DNCNT_PRESCALE_EN.

Test Plan:
- One-shot: reset, load_value=5, auto_reload=0, start pulse, enable=1.
  - count steps 5,4,3,2,1,0.
  - tc_pulse single cycle; done=1 and busy=0 from the same cycle; count holds 0.
- Periodic: load_value=3, auto_reload=1, run 20 cycles.
  - tc_pulse every 4 cycles; count sequence 3,2,1,0,3,...; done stays 0.
- Enable gating: load_value=10, drop enable for 7 cycles at count=6.
  - count holds 6 for 7 cycles, then resumes 5,4,...
- Priority and restart:
  - start+stop in the same cycle → IDLE, busy=0.
  - start with load_value=100 while at count=40 → count=100 next cycle.
- Edge values and reset:
  - load_value=0 → tc_pulse after first tick.
  - load_value=4095 periodic → no wrap glitch.
  - reset_n=0 mid-RUN → all outputs 0 next cycle.
- With DNCNT_PRESCALE_EN, PRESCALE_DIV=4, load_value=2, one-shot: count decrements every 4 cycles; done after 12 ticking cycles.
